// File: rtl/ariane_pkg.sv
// ariane_pkg
//   Minimal type definitions shared by the decode-to-issue path.
//   fu_t               : functional unit selector carried by every entry.
//   scoreboard_entry_t : one decoded instruction as handed to issue.
package ariane_pkg;

  typedef enum logic [3:0] {
    NONE      = 4'd0,
    LOAD      = 4'd1,
    STORE     = 4'd2,
    ALU       = 4'd3,
    CTRL_FLOW = 4'd4,
    MULT      = 4'd5,
    CSR       = 4'd6
  } fu_t;

  typedef struct packed {
    logic [2:0]  trans_id;
    fu_t         fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        valid;
  } scoreboard_entry_t;

  // True for entries that occupy the load/store unit.
  function automatic logic is_mem_op(input fu_t fu);
    return (fu == LOAD) || (fu == STORE);
  endfunction

endpackage

// File: rtl/issue_rx_queue.sv
// issue_rx_queue
//   Receiving end of the decode-to-issue entry handshake. Entries offered by
//   decode are acknowledged in the same cycle and buffered in a DEPTH-entry
//   FIFO that drains in order to the scoreboard-side consumer. At most one
//   control-flow entry may be resident at a time. flush_i empties the queue.
//
//   Optional feature macro: ISSUE_RX_BYPASS_EN
//     When defined, an entry offered to an empty queue while the consumer is
//     ready is forwarded combinationally to the head outputs and is never
//     written into storage.
//
//   Ports
//     clk_i, rst_ni          clock, synchronous active-low reset
//     flush_i                drop all resident entries, refuse offers
//     issue_entry_i          offered entry
//     issue_entry_valid_i    offered entry valid
//     is_ctrl_flow_i         offered entry is control flow
//     issue_instr_ack_o      offered entry taken this cycle
//     entry_o                head entry ('0 when not valid)
//     entry_valid_o          head valid
//     entry_is_ctrl_flow_o   head is control flow (0 when not valid)
//     entry_ready_i          consumer takes head
//     count_o                resident entries
//     mem_ops_o              resident LOAD/STORE entries
//
//   Handshakes
//     Upstream : an entry transfers in any cycle where issue_entry_valid_i
//                and issue_instr_ack_o are both high; ack depends only on the
//                offer, flush and registered queue state.
//     Downstream: the head transfers in any cycle where entry_valid_o and
//                entry_ready_i are both high and flush_i is low; once valid,
//                the head holds steady until it transfers or is flushed.
module issue_rx_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  scoreboard_entry_t            issue_entry_i,
  input  logic                         issue_entry_valid_i,
  input  logic                         is_ctrl_flow_i,
  output logic                         issue_instr_ack_o,
  output scoreboard_entry_t            entry_o,
  output logic                         entry_valid_o,
  output logic                         entry_is_ctrl_flow_o,
  input  logic                         entry_ready_i,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [$clog2(DEPTH):0]       mem_ops_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage and queue state
  scoreboard_entry_t  sbe_q [DEPTH];
  scoreboard_entry_t  sbe_d [DEPTH];
  logic [DEPTH-1:0]   ctrl_q, ctrl_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   mem_ops_q, mem_ops_d;
  logic               ctrl_pending_q, ctrl_pending_d;

  // Per-cycle decisions
  logic               full;
  logic               empty;
  logic               ack;
  logic               bypass;
  logic               push;
  logic               pop;
  scoreboard_entry_t  head_sbe;
  logic               head_ctrl;
  logic               push_is_mem;
  logic               pop_is_mem;

  always_comb begin
    full        = (count_q == FULL_CNT);
    empty       = (count_q == '0);
    head_sbe    = sbe_q[rd_ptr_q];
    head_ctrl   = ctrl_q[rd_ptr_q];

    // The control-flow guard uses the registered flag, so a control-flow
    // offer is refused even in the cycle its predecessor leaves the queue.
    ack = rst_ni & issue_entry_valid_i & ~flush_i & ~full
          & ~(is_ctrl_flow_i & ctrl_pending_q);

`ifdef ISSUE_RX_BYPASS_EN
    bypass = rst_ni & empty & issue_entry_valid_i & entry_ready_i & ~flush_i;
`else
    bypass = 1'b0;
`endif

    push        = ack & ~bypass;
    // A pop needs a stored head; a bypassed entry never counts as one.
    pop         = rst_ni & ~empty & entry_ready_i & ~flush_i;
    push_is_mem = is_mem_op(issue_entry_i.fu);
    pop_is_mem  = is_mem_op(head_sbe.fu);
  end

  // Next-state logic
  always_comb begin
    sbe_d          = sbe_q;
    ctrl_d         = ctrl_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    mem_ops_d      = mem_ops_q;
    ctrl_pending_d = ctrl_pending_q;

    if (flush_i) begin
      // Storage contents are left as-is; with count at zero they are dead.
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      mem_ops_d      = '0;
      ctrl_pending_d = 1'b0;
    end else begin
      if (push) begin
        sbe_d[wr_ptr_q]  = issue_entry_i;
        ctrl_d[wr_ptr_q] = is_ctrl_flow_i;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
      mem_ops_d = mem_ops_q + CNT_W'(push & push_is_mem)
                            - CNT_W'(pop & pop_is_mem);
      // Clear first so a control-flow push in the same cycle wins.
      if (pop && head_ctrl) begin
        ctrl_pending_d = 1'b0;
      end
      if (push && is_ctrl_flow_i) begin
        ctrl_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        sbe_q[i] <= '0;
      end
      ctrl_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      mem_ops_q      <= '0;
      ctrl_pending_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        sbe_q[i] <= sbe_d[i];
      end
      ctrl_q         <= ctrl_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      mem_ops_q      <= mem_ops_d;
      ctrl_pending_q <= ctrl_pending_d;
    end
  end

  // Outputs. Everything is forced low while reset is asserted so nothing
  // leaks out before the first clock edge clears the state.
  always_comb begin
    issue_instr_ack_o    = ack;
    entry_valid_o        = rst_ni & (~empty | bypass);
    entry_o              = '0;
    entry_is_ctrl_flow_o = 1'b0;
    if (rst_ni && !empty) begin
      entry_o              = head_sbe;
      entry_is_ctrl_flow_o = head_ctrl;
    end else if (bypass) begin
      entry_o              = issue_entry_i;
      entry_is_ctrl_flow_o = is_ctrl_flow_i;
    end
    count_o   = rst_ni ? count_q   : '0;
    mem_ops_o = rst_ni ? mem_ops_q : '0;
  end

  // Structural invariants
  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= FULL_CNT);
  a_mem_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_ops_q <= count_q);
  a_single_ctrl : assert property (@(posedge clk_i) disable iff (!rst_ni)
    issue_instr_ack_o |-> !(is_ctrl_flow_i && ctrl_pending_q));

endmodule

// File: tb/tb_issue_rx_queue.sv
// tb_issue_rx_queue
//   Drives issue_rx_queue with directed scenarios followed by randomized
//   traffic and compares every cycle against a queue-based reference model.
module tb_issue_rx_queue;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SBE_W = $bits(scoreboard_entry_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_ni = 1'b0;
  logic               flush_i = 1'b0;
  scoreboard_entry_t  issue_entry_i = '0;
  logic               issue_entry_valid_i = 1'b0;
  logic               is_ctrl_flow_i = 1'b0;
  logic               issue_instr_ack_o;
  scoreboard_entry_t  entry_o;
  logic               entry_valid_o;
  logic               entry_is_ctrl_flow_o;
  logic               entry_ready_i = 1'b0;
  logic [CNT_W-1:0]   count_o;
  logic [CNT_W-1:0]   mem_ops_o;

  issue_rx_queue #(.DEPTH(DEPTH)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_ni),
    .flush_i              (flush_i),
    .issue_entry_i        (issue_entry_i),
    .issue_entry_valid_i  (issue_entry_valid_i),
    .is_ctrl_flow_i       (is_ctrl_flow_i),
    .issue_instr_ack_o    (issue_instr_ack_o),
    .entry_o              (entry_o),
    .entry_valid_o        (entry_valid_o),
    .entry_is_ctrl_flow_o (entry_is_ctrl_flow_o),
    .entry_ready_i        (entry_ready_i),
    .count_o              (count_o),
    .mem_ops_o            (mem_ops_o)
  );

  // ---------------- scoreboard ----------------
  // Each element is {is_ctrl_flow, entry}; index 0 is the head.
  logic [SBE_W:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_ctrl_resident();
    foreach (exp_q[i]) if (exp_q[i][SBE_W]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_mem_ops();
    int n = 0;
    scoreboard_entry_t e;
    foreach (exp_q[i]) begin
      e = scoreboard_entry_t'(exp_q[i][SBE_W-1:0]);
      if (e.fu == LOAD || e.fu == STORE) n++;
    end
    return n;
  endfunction

  // ---------------- driver ----------------
  function automatic scoreboard_entry_t make_entry(input fu_t f);
    scoreboard_entry_t e;
    e          = '0;
    e.fu       = f;
    e.trans_id = 3'($urandom);
    e.op       = 7'($urandom);
    e.rs1      = 5'($urandom);
    e.rs2      = 5'($urandom);
    e.rd       = 5'($urandom);
    e.result   = $urandom;
    e.valid    = 1'b1;
    return e;
  endfunction

  function automatic fu_t rand_fu();
    case ($urandom_range(0, 4))
      0: return LOAD;
      1: return STORE;
      2: return CTRL_FLOW;
      3: return MULT;
      default: return ALU;
    endcase
  endfunction

  // One clock cycle: drive at negedge, compare 1 time unit later, then
  // advance the model to the state after the coming posedge.
  task automatic step(input logic rst, input logic v, input scoreboard_entry_t e,
                      input logic c, input logic rdy, input logic fl);
    logic              exp_ack;
    logic              byp;
    logic              exp_valid;
    logic              exp_hctrl;
    scoreboard_entry_t exp_head;
    int                sz;
    @(negedge clk);
    rst_ni              = rst;
    issue_entry_valid_i = v;
    issue_entry_i       = e;
    is_ctrl_flow_i      = c;
    entry_ready_i       = rdy;
    flush_i             = fl;
    #1;
    sz      = exp_q.size();
    exp_ack = rst & v & ~fl & (sz < int'(DEPTH)) & ~(c & model_ctrl_resident());
    byp     = 1'b0;
`ifdef ISSUE_RX_BYPASS_EN
    byp = rst & (sz == 0) & v & rdy & ~fl;
`endif
    exp_valid = rst & ((sz > 0) | byp);
    exp_head  = '0;
    exp_hctrl = 1'b0;
    if (rst && sz > 0) begin
      exp_head  = scoreboard_entry_t'(exp_q[0][SBE_W-1:0]);
      exp_hctrl = exp_q[0][SBE_W];
    end else if (byp) begin
      exp_head  = e;
      exp_hctrl = c;
    end
    check("ack",       64'(issue_instr_ack_o),    64'(exp_ack));
    check("valid",     64'(entry_valid_o),        64'(exp_valid));
    check("head",      64'(entry_o),              64'(exp_head));
    check("head_ctrl", 64'(entry_is_ctrl_flow_o), 64'(exp_hctrl));
    check("count",     64'(count_o),              64'(rst ? sz : 0));
    check("mem_ops",   64'(mem_ops_o),            64'(rst ? model_mem_ops() : 0));
    if (!rst || fl) begin
      exp_q.delete();
    end else begin
      if (sz > 0 && rdy) void'(exp_q.pop_front());
      if (exp_ack && !byp) exp_q.push_back({c, e});
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b1, 1'b0, '0, 1'b0, rdy, 1'b0);
  endtask

  task automatic offer(input fu_t f, input logic rdy);
    step(1'b1, 1'b1, make_entry(f), f == CTRL_FLOW, rdy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held two cycles with a valid offer present.
    step(1'b0, 1'b1, make_entry(ALU), 1'b0, 1'b1, 1'b0);
    check("rst_ack", 64'(issue_instr_ack_o), 64'(0));
    step(1'b0, 1'b1, make_entry(ALU), 1'b0, 1'b1, 1'b0);
    check("rst_count", 64'(count_o), 64'(0));

    // Fill with ready low: four accepted, fifth refused.
    for (int i = 0; i < 4; i++) offer(ALU, 1'b0);
    offer(ALU, 1'b0);
    check("full_ack", 64'(issue_instr_ack_o), 64'(0));
    check("full_count", 64'(count_o), 64'(4));
    // Pop while full: offer still refused this cycle, accepted next.
    offer(ALU, 1'b1);
    check("full_pop_ack", 64'(issue_instr_ack_o), 64'(0));
    offer(ALU, 1'b1);
    check("after_pop_ack", 64'(issue_instr_ack_o), 64'(1));
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Control-flow rule.
    offer(CTRL_FLOW, 1'b0);
    offer(CTRL_FLOW, 1'b0);
    check("ctrl_block", 64'(issue_instr_ack_o), 64'(0));
    offer(CTRL_FLOW, 1'b1);   // first branch pops now; second still refused
    check("ctrl_pop_same", 64'(issue_instr_ack_o), 64'(0));
    offer(CTRL_FLOW, 1'b0);
    check("ctrl_next", 64'(issue_instr_ack_o), 64'(1));
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Memory-op count.
    offer(LOAD, 1'b0);
    offer(STORE, 1'b0);
    offer(ALU, 1'b0);
    idle(1'b1);               // LOAD pops
    check("mem_two", 64'(mem_ops_o), 64'(2));
    offer(LOAD, 1'b1);        // STORE pops, LOAD pushed
    check("mem_one", 64'(mem_ops_o), 64'(1));
    idle(1'b0);
    check("mem_net", 64'(mem_ops_o), 64'(1));

    // Flush with resident entries and a valid offer.
    step(1'b1, 1'b1, make_entry(LOAD), 1'b0, 1'b1, 1'b1);
    check("flush_ack", 64'(issue_instr_ack_o), 64'(0));
    offer(CTRL_FLOW, 1'b0);
    check("flush_count", 64'(count_o), 64'(0));
    check("post_flush_ack", 64'(issue_instr_ack_o), 64'(1));
    for (int i = 0; i < 2; i++) idle(1'b1);

    // Randomized traffic with occasional flush and mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      fu_t  f;
      logic c;
      f = rand_fu();
      c = (f == CTRL_FLOW) ? 1'b1 : ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 9) < 7,
           make_entry(f), c,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
